alu_serial_seq: RTL and testbench



---
 rtl/alu_serial_seq_pkg.sv | 18 +
 rtl/alu_1bit.sv | 29 ++
 rtl/alu_serial_seq.sv | 104 ++++++++++
 tb/tb_alu_serial_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes and FSM states.
// The optional subtract path is enabled by defining ALU_SERIAL_SUB_EN.
package alu_serial_seq_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_XOR = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } aluOp_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: full adder for ADD, plain gates for the logic ops.
// Logic ops never produce a carry so the sequencer's carry flag reads 0 for them.
module alu_1bit
    import alu_serial_seq_pkg::*;
(
    input  logic   rs1_i,
    input  logic   rs2_i,
    input  logic   carry_i,
    input  aluOp_e alu_op_i,
    output logic   result_o,
    output logic   carry_o
);

    always_comb begin
        result_o = 1'b0;
        carry_o  = 1'b0;
        case (alu_op_i)
            ALU_ADD: begin
                result_o = rs1_i ^ rs2_i ^ carry_i;
                carry_o  = (rs1_i & rs2_i) | (carry_i & (rs1_i ^ rs2_i));
            end
            ALU_XOR: result_o = rs1_i ^ rs2_i;
            ALU_AND: result_o = rs1_i & rs2_i;
            ALU_OR:  result_o = rs1_i | rs2_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial execute sequencer: streams two operands LSB-first through one alu_1bit.
// Define ALU_SERIAL_SUB_EN to turn ADD with sub=1 into a - b.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] aSh_q, bSh_q, resSh_q;
    aluOp_e           op_q;
    logic             carry_q, nz_q;
    logic [CNT_W-1:0] cnt_q;

    logic accept, lastBit, loadSub, aluRes, aluCarry;

    assign accept  = in_valid & in_ready;
    assign lastBit = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_SERIAL_SUB_EN
    assign loadSub = (aluOp_e'(op) == ALU_ADD) & sub;
`else
    logic unusedSub;
    assign unusedSub = sub;
    assign loadSub   = 1'b0;
`endif

    alu_1bit u_alu (
        .rs1_i    (aSh_q[0]),
        .rs2_i    (bSh_q[0]),
        .carry_i  (carry_q),
        .alu_op_i (op_q),
        .result_o (aluRes),
        .carry_o  (aluCarry)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (lastBit) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            aSh_q   <= '0;
            bSh_q   <= '0;
            resSh_q <= '0;
            op_q    <= ALU_ADD;
            carry_q <= 1'b0;
            nz_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            aSh_q   <= a;
            bSh_q   <= loadSub ? ~b : b;
            op_q    <= aluOp_e'(op);
            carry_q <= loadSub;
            nz_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (state_q == ST_SHIFT) begin
            resSh_q <= {aluRes, resSh_q[WIDTH-1:1]};
            aSh_q   <= aSh_q >> 1;
            bSh_q   <= bSh_q >> 1;
            carry_q <= aluCarry;
            nz_q    <= nz_q | aluRes;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign result     = resSh_q;
    assign carry_flag = out_valid & carry_q;
    assign zero_flag  = out_valid & ~nz_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized self-checking bench for alu_serial_seq against an arithmetic reference model.
// Follows ALU_SERIAL_SUB_EN the same way the design does.
module tb_alu_serial_seq;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             sub;
    logic [WIDTH-1:0] a, b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_flag;
    logic             zero_flag;

    int checkCount = 0;
    int errorCount = 0;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .sub        (sub),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: whole-word arithmetic, carry is bit WIDTH of the wide sum.
    function automatic logic [WIDTH:0] modelOp(input logic [1:0] mOp, input logic mSub,
                                               input logic [WIDTH-1:0] mA, input logic [WIDTH-1:0] mB);
        logic [WIDTH:0] wide;
        logic           useSub;
`ifdef ALU_SERIAL_SUB_EN
        useSub = mSub;
`else
        useSub = 1'b0;
`endif
        case (mOp)
            2'b00:   wide = useSub ? ({1'b0, mA} + {1'b0, ~mB} + 1) : ({1'b0, mA} + {1'b0, mB});
            2'b01:   wide = {1'b0, mA ^ mB};
            2'b10:   wide = {1'b0, mA & mB};
            default: wide = {1'b0, mA | mB};
        endcase
        return wide;
    endfunction

    // Issues one operation, waits for the result, optionally stalls it, then retires it.
    task automatic applyStimulus(input logic [1:0] tOp, input logic tSub,
                                 input logic [WIDTH-1:0] tA, input logic [WIDTH-1:0] tB,
                                 input int hold);
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] heldRes;
        logic             heldCarry, heldZero;
        int               cycles;
        exp = modelOp(tOp, tSub, tA, tB);
        checkOutput("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = tOp;
        sub       = tSub;
        a         = tA;
        b         = tB;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        sub      = 1'($urandom);
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency", 32'(cycles), 32'(WIDTH));
        checkOutput("result", 32'(result), 32'(exp[WIDTH-1:0]));
        checkOutput("carry_flag", 32'(carry_flag), 32'(exp[WIDTH]));
        checkOutput("zero_flag", 32'(zero_flag), 32'(exp[WIDTH-1:0] == '0));
        heldRes   = result;
        heldCarry = carry_flag;
        heldZero  = zero_flag;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_result", 32'(result), 32'(heldRes));
            checkOutput("hold_flags", {30'd0, carry_flag, zero_flag}, {30'd0, heldCarry, heldZero});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("retire_out_valid", 32'(out_valid), 32'd0);
        checkOutput("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        sub       = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", {30'd0, carry_flag, zero_flag}, 32'd0);
        rst = 1'b0;

        applyStimulus(2'b00, 1'b0, 16'h00FF, 16'h0001, 0);
        applyStimulus(2'b00, 1'b0, 16'hFFFF, 16'h0001, 0);
        applyStimulus(2'b01, 1'b0, 16'hA5A5, 16'hFFFF, 0);
        applyStimulus(2'b10, 1'b0, 16'hF0F0, 16'h0FF0, 0);
        applyStimulus(2'b11, 1'b0, 16'h1200, 16'h0034, 0);
        applyStimulus(2'b00, 1'b0, 16'h4321, 16'h1111, 5);

        // Abort an ADD mid-stream with reset
        in_valid = 1'b1;
        op       = 2'b00;
        sub      = 1'b0;
        a        = 16'h1234;
        b        = 16'h1111;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_result", 32'(result), 32'd0);
        applyStimulus(2'b00, 1'b0, 16'h0001, 16'h0001, 0);

        applyStimulus(2'b00, 1'b1, 16'h0005, 16'h0007, 0);
        applyStimulus(2'b00, 1'b1, 16'h0007, 16'h0005, 1);
        applyStimulus(2'b01, 1'b1, 16'h00F0, 16'h0F00, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
